// File: rtl/sap_pkg.sv
// Shared definitions for the SAP sequencer: state encoding and wait-timer helpers.
// The decoder and verification code import this to interpret the state encoding.
package sap_pkg;

    // Sequencer states, 3-bit encoding; codes 5..7 are illegal and recover to F_ADDR.
    typedef enum logic [2:0] {
        F_ADDR = 3'd0,
        F_READ = 3'd1,
        F_LOAD = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } sap_state_t;

    // Width of the consecutive-wait counter.
    localparam int WAIT_CNT_W = 8;

    // Counter value on the last permitted wait cycle: a read that is still not
    // ready while the counter holds this value has waited TIMEOUT cycles.
    function automatic logic [WAIT_CNT_W-1:0] timeout_limit(input int timeout);
        return WAIT_CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/sap_wait_timer.sv
// Consecutive-wait counter shared by fetch-read and execute-read stalls.
// expired is high on the wait cycle that uses up the TIMEOUT budget.
module sap_wait_timer
    import sap_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wait_req,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT   = timeout_limit(TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    logic [WAIT_CNT_W-1:0] wait_cnt_reg;

    // Count stalled cycles; any non-stalled cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (clear) begin
            wait_cnt_reg <= '0;
        end else if (wait_req) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
        end
    end

    assign expired = wait_req && !clear && (wait_cnt_reg == LIMIT);

endmodule

// File: rtl/sap_microsequencer.sv
// SAP fetch/execute microsequencer: drives PC/MAR/RAM/IR fetch micro-ops, runs
// a variable-length execute step counter, waits on mem_ready with a timeout
// fault, supports halt/resume at instruction boundaries and counts retirements.
module sap_microsequencer
    import sap_pkg::*;
#(
    parameter int STEP_W  = 3,
    parameter int WAIT_EN = 1,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STEP_W-1:0] steps_required,
    input  logic              exec_mar_load,
    input  logic              exec_ram_read,
    input  logic              mem_ready,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_enable,
    output logic              mar_load,
    output logic              ram_read,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              fetch_complete,
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic              bus_fault,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic              WAIT_ON  = (WAIT_EN != 0);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    sap_state_t        state_reg;
    logic [STEP_W-1:0] step_reg;
    logic              bus_fault_reg;
    logic [CNT_W-1:0]  instr_count_reg;

    logic read_stall;
    logic exec_stall;
    logic wait_req;
    logic expired;

    // A fetch read stalls on every not-ready cycle; an execute cycle stalls only
    // when the decoder actually asked for a RAM read.
    assign read_stall = WAIT_ON && !mem_ready;
    assign exec_stall = WAIT_ON && exec_ram_read && !mem_ready;
    assign wait_req   = ((state_reg == F_READ) && read_stall) ||
                        ((state_reg == EXEC)   && exec_stall);

    sap_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!wait_req),
        .wait_req (wait_req),
        .expired  (expired)
    );

    // Sequencer state, execute step, sticky fault and retirement counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= F_ADDR;
            step_reg        <= '0;
            bus_fault_reg   <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            case (state_reg)
                F_ADDR: begin
                    state_reg <= F_READ;
                end
                F_READ: begin
                    if (!read_stall) begin
                        state_reg <= F_LOAD;
                    end else if (expired) begin
                        bus_fault_reg <= 1'b1;
                        state_reg     <= HALT;
                    end
                end
                F_LOAD: begin
                    state_reg <= EXEC;
                    step_reg  <= '0;
                end
                EXEC: begin
                    if (exec_stall) begin
                        if (expired) begin
                            bus_fault_reg <= 1'b1;
                            state_reg     <= HALT;
                            step_reg      <= '0;
                        end
                    end else if (step_reg != steps_required) begin
                        step_reg <= step_reg + STEP_ONE;
                    end else begin
                        // Instruction boundary: the only place halt_req is honoured.
                        step_reg        <= '0;
                        instr_count_reg <= instr_count_reg + CNT_ONE;
                        state_reg       <= halt_req ? HALT : F_ADDR;
                    end
                end
                HALT: begin
                    step_reg <= '0;
                    if (resume) begin
                        state_reg     <= F_ADDR;
                        bus_fault_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= F_ADDR;
                    step_reg  <= '0;
                end
            endcase
        end
    end

    // Control decode: Moore on state, with the decoder requests passed through in EXEC.
    always_comb begin
        pc_enable      = 1'b0;
        mar_load       = 1'b0;
        ram_read       = 1'b0;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        fetch_complete = 1'b0;
        halted         = 1'b0;
        case (state_reg)
            F_ADDR: begin
                pc_enable = 1'b1;
                mar_load  = 1'b1;
            end
            F_READ: begin
                ram_read = 1'b1;
            end
            F_LOAD: begin
                ram_read = 1'b1;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
            end
            EXEC: begin
                fetch_complete = 1'b1;
                mar_load       = exec_mar_load;
                ram_read       = exec_ram_read;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    assign step        = step_reg;
    assign bus_fault   = bus_fault_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer. Main instance: WAIT_EN=1, TIMEOUT=15.
// Second instance: WAIT_EN=0 with a 3-bit counter to exercise counter wrap.
// Inputs are driven on the falling edge for the cycle that follows; outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_sap_microsequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] steps_required;
    logic       exec_mar_load, exec_ram_read, mem_ready, halt_req, resume;
    logic       pc_enable, mar_load, ram_read, ir_load, pc_inc, fetch_complete;
    logic [2:0] step;
    logic       halted, bus_fault;
    logic [15:0] instr_count;

    logic       rst2;
    logic       pc_enable2, mar_load2, ram_read2, ir_load2, pc_inc2, fetch_complete2;
    logic [2:0] step2;
    logic       halted2, bus_fault2;
    logic [2:0] instr_count2;

    int checks   = 0;
    int failures = 0;

    // Control vector: {pc_enable, mar_load, ram_read, ir_load, pc_inc, fetch_complete, halted}
    logic [6:0] ctrl1, ctrl2;
    assign ctrl1 = {pc_enable, mar_load, ram_read, ir_load, pc_inc, fetch_complete, halted};
    assign ctrl2 = {pc_enable2, mar_load2, ram_read2, ir_load2, pc_inc2, fetch_complete2, halted2};

    localparam logic [6:0] C_FADDR = 7'h60;
    localparam logic [6:0] C_FREAD = 7'h10;
    localparam logic [6:0] C_FLOAD = 7'h1C;
    localparam logic [6:0] C_EXEC  = 7'h02;
    localparam logic [6:0] C_EXRD  = 7'h12;
    localparam logic [6:0] C_HALT  = 7'h01;

    always #5 clk = ~clk;

    sap_microsequencer #(.STEP_W(3), .WAIT_EN(1), .TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .steps_required(steps_required),
        .exec_mar_load(exec_mar_load), .exec_ram_read(exec_ram_read),
        .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
        .pc_enable(pc_enable), .mar_load(mar_load), .ram_read(ram_read),
        .ir_load(ir_load), .pc_inc(pc_inc), .fetch_complete(fetch_complete),
        .step(step), .halted(halted), .bus_fault(bus_fault), .instr_count(instr_count)
    );

    sap_microsequencer #(.STEP_W(3), .WAIT_EN(0), .TIMEOUT(15), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst2), .steps_required(3'd0),
        .exec_mar_load(1'b0), .exec_ram_read(1'b0),
        .mem_ready(1'b0), .halt_req(1'b0), .resume(1'b0),
        .pc_enable(pc_enable2), .mar_load(mar_load2), .ram_read(ram_read2),
        .ir_load(ir_load2), .pc_inc(pc_inc2), .fetch_complete(fetch_complete2),
        .step(step2), .halted(halted2), .bus_fault(bus_fault2), .instr_count(instr_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        steps_required = 3'd2;
        exec_mar_load = 1'b0; exec_ram_read = 1'b0;
        mem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_ctrl", ctrl1, C_FADDR);
        chk("rst_step", step, 0);
        chk("rst_fault", bus_fault, 0);
        chk("rst_count", instr_count, 0);
        $display("txn reset: ctrl=%h step=%0d count=%0d", ctrl1, step, instr_count);

        // Basic fetch + 3-step execute, no waits
        @(negedge clk); rst = 1'b0; #1;
        chk("t1_faddr", ctrl1, C_FADDR);
        @(negedge clk); #1; chk("t1_fread", ctrl1, C_FREAD);
        @(negedge clk); #1; chk("t1_fload", ctrl1, C_FLOAD);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); #1;
            chk("t1_exec_ctrl", ctrl1, C_EXEC);
            chk("t1_exec_step", step, s);
            chk("t1_exec_count", instr_count, 0);
        end
        @(negedge clk); #1;
        chk("t1_next_faddr", ctrl1, C_FADDR);
        chk("t1_count", instr_count, 1);
        $display("txn basic instruction: count=%0d", instr_count);

        // mem_ready low for 4 cycles in F_READ
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = (i == 4); #1;
            chk("t2_fread_wait", ctrl1, C_FREAD);
        end
        @(negedge clk); #1;
        chk("t2_fload", ctrl1, C_FLOAD);
        $display("txn fetch wait 4 cycles: ir_load=%b", ir_load);

        // Execute stall at step 1 for 3 cycles
        @(negedge clk); #1;
        chk("t5_s0_ctrl", ctrl1, C_EXEC);
        chk("t5_s0_step", step, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); exec_ram_read = 1'b1; mem_ready = (k == 3); #1;
            chk("t5_stall_ctrl", ctrl1, C_EXRD);
            chk("t5_stall_step", step, 1);
        end
        @(negedge clk); exec_ram_read = 1'b0; #1;
        chk("t5_s2_ctrl", ctrl1, C_EXEC);
        chk("t5_s2_step", step, 2);
        @(negedge clk); #1;
        chk("t5_faddr", ctrl1, C_FADDR);
        chk("t5_count", instr_count, 2);
        $display("txn exec stall 3 cycles: count=%0d", instr_count);

        // halt_req raised at step 1 of a 4-step instruction
        steps_required = 3'd3;
        @(negedge clk); #1; chk("t4_fread", ctrl1, C_FREAD);
        @(negedge clk); #1; chk("t4_fload", ctrl1, C_FLOAD);
        @(negedge clk); #1; chk("t4_s0", step, 0);
        @(negedge clk); halt_req = 1'b1; #1;
        chk("t4_s1", step, 1);
        chk("t4_s1_ctrl", ctrl1, C_EXEC);
        @(negedge clk); #1; chk("t4_s2", step, 2);
        @(negedge clk); #1;
        chk("t4_s3", step, 3);
        chk("t4_s3_count", instr_count, 2);
        @(negedge clk); #1;
        chk("t4_halt_ctrl", ctrl1, C_HALT);
        chk("t4_halt_step", step, 0);
        chk("t4_halt_count", instr_count, 3);
        @(negedge clk); #1; chk("t4_halt_hold", ctrl1, C_HALT);
        @(negedge clk); resume = 1'b1; #1; chk("t4_halt_resume", ctrl1, C_HALT);
        @(negedge clk); resume = 1'b0; halt_req = 1'b0; #1;
        chk("t4_resumed", ctrl1, C_FADDR);
        chk("t4_fault", bus_fault, 0);
        $display("txn halt/resume: count=%0d", instr_count);

        // Fetch read timeout after 15 wait cycles
        steps_required = 3'd0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            chk("t3_wait_ctrl", ctrl1, C_FREAD);
            chk("t3_wait_fault", bus_fault, 0);
        end
        @(negedge clk); #1;
        chk("t3_halt_ctrl", ctrl1, C_HALT);
        chk("t3_fault", bus_fault, 1);
        @(negedge clk); #1;
        chk("t3_fault_hold", bus_fault, 1);
        chk("t3_halt_hold", ctrl1, C_HALT);
        @(negedge clk); resume = 1'b1; #1; chk("t3_resume_cycle", ctrl1, C_HALT);
        @(negedge clk); resume = 1'b0; mem_ready = 1'b1; #1;
        chk("t3_restart", ctrl1, C_FADDR);
        chk("t3_fault_clear", bus_fault, 0);
        chk("t3_count", instr_count, 3);
        $display("txn read timeout: fault cleared, count=%0d", instr_count);

        // Async reset mid-F_READ
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("t6_fread", ctrl1, C_FREAD);
        #2 rst = 1'b1; #1;
        chk("t6_async_ctrl", ctrl1, C_FADDR);
        chk("t6_async_step", step, 0);
        chk("t6_async_count", instr_count, 0);
        chk("t6_async_fault", bus_fault, 0);
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;
        chk("t6_release", ctrl1, C_FADDR);
        @(negedge clk); #1; chk("t6_fread2", ctrl1, C_FREAD);
        $display("txn async reset mid-read: count=%0d", instr_count);

        // WAIT_EN=0 instance: mem_ready ignored, one-cycle execute, 3-bit count wraps
        @(negedge clk); rst2 = 1'b0; #1;
        chk("w_faddr0", ctrl2, C_FADDR);
        for (int n = 1; n <= 9; n++) begin
            logic [31:0] nv;
            logic [2:0]  exp_cnt;
            nv = n;
            exp_cnt = nv[2:0];
            @(negedge clk); #1; chk("w_fread", ctrl2, C_FREAD);
            @(negedge clk); #1; chk("w_fload", ctrl2, C_FLOAD);
            @(negedge clk); #1;
            chk("w_exec", ctrl2, C_EXEC);
            chk("w_step", step2, 0);
            @(negedge clk); #1;
            chk("w_faddr", ctrl2, C_FADDR);
            chk("w_count", instr_count2, exp_cnt);
            $display("txn nowait instr %0d: count=%0d", n, instr_count2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
